// File: rtl/vga_scanout.sv
// VGA raster scan-out: timing counters, one frame-buffer read per visible pixel, registered RGB/DE/syncs.
// Latency: counter position to pixel/de/syncs is fixed at 2 cycles; no backpressure (buffer must answer next cycle).
module vga_scanout #(
    parameter int DATAW    = 24,
    parameter int ADDRW    = 20,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    output logic             rd_en_o,
    output logic [ADDRW-1:0] rd_addr_o,
    input  logic [DATAW-1:0] rd_data_i,
    output logic [DATAW-1:0] pixel_o,
    output logic             de_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             frame_start_o,
    output logic             busy_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [HCW-1:0]   hcnt_q, hcnt_d;
    logic [VCW-1:0]   vcnt_q, vcnt_d;
    logic             flush_q, flush_d;
    logic             rd_en_q, rd_en_d;
    logic [ADDRW-1:0] rd_addr_q, rd_addr_d;

    logic             h_last, v_last;
    logic             hs_act, vs_act, fs_act;
    logic             de_d1_q, hs_d1_q, vs_d1_q, fs_d1_q;
    logic [DATAW-1:0] pixel_q;
    logic             de_q, hsync_q, vsync_q, frame_start_q;

    assign h_last = int'(hcnt_q) == H_TOTAL - 1;
    assign v_last = int'(vcnt_q) == V_TOTAL - 1;

    // Sync/frame markers are evaluated on the counters that rd_en_q belongs to,
    // so the two-stage delay below lines them up with the returned pixel.
    assign hs_act = (state_q == RUN) && (int'(hcnt_q) >= HS_BEG) && (int'(hcnt_q) < HS_END);
    assign vs_act = (state_q == RUN) && (int'(vcnt_q) >= VS_BEG) && (int'(vcnt_q) < VS_END);
    assign fs_act = (state_q == RUN) && (hcnt_q == '0) && (vcnt_q == '0);

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        flush_d = flush_q;
        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (en_i) state_d = RUN;
            end
            RUN: begin
                if (!h_last) begin
                    hcnt_d = hcnt_q + HCW'(1);
                end else if (!v_last) begin
                    hcnt_d = '0;
                    vcnt_d = vcnt_q + VCW'(1);
                end else if (en_i) begin
                    hcnt_d = '0;
                    vcnt_d = '0;
                end else begin
                    state_d = FLUSH;
                    flush_d = 1'b0;
                end
            end
            FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                    vcnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read request is registered so it appears alongside the counter value it addresses.
        rd_en_d   = (state_d == RUN) && (int'(hcnt_d) < H_ACTIVE) && (int'(vcnt_d) < V_ACTIVE);
        rd_addr_d = rd_addr_q;
        if (rd_en_d) begin
            rd_addr_d = (hcnt_d == '0 && vcnt_d == '0) ? ADDRW'(1) : rd_addr_q + ADDRW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            flush_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            de_d1_q       <= 1'b0;
            hs_d1_q       <= 1'b0;
            vs_d1_q       <= 1'b0;
            fs_d1_q       <= 1'b0;
            pixel_q       <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            flush_q       <= flush_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            de_d1_q       <= rd_en_q;
            hs_d1_q       <= hs_act;
            vs_d1_q       <= vs_act;
            fs_d1_q       <= fs_act;
            pixel_q       <= de_d1_q ? rd_data_i : '0;
            de_q          <= de_d1_q;
            hsync_q       <= hs_d1_q ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= vs_d1_q ? SYNC_POL : ~SYNC_POL;
            frame_start_q <= fs_d1_q;
        end
    end

    assign rd_en_o       = rd_en_q;
    assign rd_addr_o     = rd_addr_q;
    assign pixel_o       = pixel_q;
    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign frame_start_o = frame_start_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout with a reduced raster; reference model tracks a linear frame position.
module tb_vga_scanout;

    localparam int DW  = 24;
    localparam int AW  = 20;
    localparam int HA  = 6;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          en_i;
    logic          rd_en_o;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_i;
    logic [DW-1:0] pixel_o;
    logic          de_o, hsync_o, vsync_o, frame_start_o, busy_o;

    always #5 clk_i = ~clk_i;

    vga_scanout #(
        .DATAW(DW), .ADDRW(AW),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b0)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .pixel_o(pixel_o), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .frame_start_o(frame_start_o), .busy_o(busy_o)
    );

    // Frame buffer: registered read, garbage on the bus when not reading.
    logic [DW-1:0] mem [0:63];
    always @(posedge clk_i) rd_data_i <= rd_en_o ? mem[rd_addr_o[5:0]] : DW'($urandom);

    typedef struct packed {
        logic          vis;
        logic [DW-1:0] pix;
        logic          hs;
        logic          vs;
        logic          fs;
    } st_t;

    int            m_mode;   // 0 idle, 1 scanning, 2 draining
    int            m_p;
    int            m_fl;
    logic [AW-1:0] m_addr;
    st_t           s_cur, s_d1, e_out;

    int errs = 0;
    int checks = 0;
    logic win_on = 1'b0;
    int cnt_de = 0, cnt_hs = 0, cnt_vs = 0, cnt_fs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e);
        int  x, y;
        logic run;
        if (r) begin
            m_mode = 0; m_p = 0; m_fl = 0; m_addr = '0;
            s_cur = '0; s_d1 = '0; e_out = '0;
        end else begin
            case (m_mode)
                0: if (e) begin m_mode = 1; m_p = 0; end
                1: if (m_p == FRAME - 1) begin
                       if (e) m_p = 0;
                       else begin m_mode = 2; m_fl = 2; end
                   end else m_p++;
                default: begin
                    m_fl--;
                    if (m_fl == 0) begin m_mode = 0; m_p = 0; end
                end
            endcase
            x   = m_p % HT;
            y   = m_p / HT;
            run = (m_mode == 1);
            e_out = s_d1;
            s_d1  = s_cur;
            s_cur.vis = run && x < HA && y < VA;
            if (s_cur.vis) m_addr = AW'(y * HA + x + 1);
            s_cur.pix = s_cur.vis ? mem[m_addr[5:0]] : '0;
            s_cur.hs  = run && x >= HA + HFP && x < HA + HFP + HS;
            s_cur.vs  = run && y >= VA + VFP && y < VA + VFP + VS;
            s_cur.fs  = run && m_p == 0;
        end
    endtask

    task automatic cycle(input logic r, input logic e);
        reset_i = r;
        en_i    = e;
        @(posedge clk_i);
        model_step(r, e);
        #1;
        chk("rd_en",       32'(rd_en_o),       32'(s_cur.vis));
        chk("rd_addr",     32'(rd_addr_o),     32'(m_addr));
        chk("de",          32'(de_o),          32'(e_out.vis));
        chk("pixel",       32'(pixel_o),       32'(e_out.pix));
        chk("hsync",       32'(hsync_o),       32'(!e_out.hs));
        chk("vsync",       32'(vsync_o),       32'(!e_out.vs));
        chk("frame_start", 32'(frame_start_o), 32'(e_out.fs));
        chk("busy",        32'(busy_o),        32'(m_mode != 0));
        if (win_on) begin
            if (de_o)          cnt_de++;
            if (!hsync_o)      cnt_hs++;
            if (!vsync_o)      cnt_vs++;
            if (frame_start_o) cnt_fs++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
        reset_i = 1'b1;
        en_i    = 1'b0;

        repeat (3) cycle(1'b1, 1'b0);

        // One-shot frame: en pulsed once, frame completes, drains, idles.
        cycle(1'b0, 1'b1);
        repeat (FRAME + 10) cycle(1'b0, 1'b0);

        // Continuous scanning; exactly three frame periods measured.
        repeat (FRAME + 7) cycle(1'b0, 1'b1);
        win_on = 1'b1;
        repeat (3 * FRAME) cycle(1'b0, 1'b1);
        win_on = 1'b0;
        chk("win_de_cycles",    32'(cnt_de), 32'(3 * HA * VA));
        chk("win_hsync_cycles", 32'(cnt_hs), 32'(3 * VT * HS));
        chk("win_vsync_cycles", 32'(cnt_vs), 32'(3 * HT * VS));
        chk("win_frame_starts", 32'(cnt_fs), 32'(3));

        // Reset in the middle of a frame, then restart.
        repeat (FRAME / 2 + 3) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (FRAME + 20) cycle(1'b0, 1'b1);

        // Randomized enable and occasional resets.
        repeat (1500) cycle(($urandom % 200) == 0, ($urandom % 4) != 0);
        repeat (600) cycle(($urandom % 300) == 0, ($urandom % 3) == 0);

        // Drain to idle.
        repeat (2 * FRAME) cycle(1'b0, 1'b0);
        chk("final_idle_busy", 32'(busy_o), 32'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
